// File: rtl/reg_scoreboard_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// reg_scoreboard_if : issue/source/writeback bundle for reg_scoreboard
// Rev 1.0
// ---------------------------------------------------------------------------
interface reg_scoreboard_if #(
  parameter int NUM_REGS = 33,
  parameter int IDX_W    = 6,
  parameter int NUM_SRC  = 3,
  parameter int NUM_WB   = 2
);
  logic [NUM_SRC-1:0]        src_valid;
  logic [NUM_SRC*IDX_W-1:0]  src_reg;
  logic                      iss_valid;
  logic [1:0]                iss_dst_valid;
  logic [2*IDX_W-1:0]        iss_dst_reg;
  logic                      iss_ready;
  logic [NUM_WB-1:0]         wb_valid;
  logic [NUM_WB*IDX_W-1:0]   wb_reg;
  logic                      flush;
  logic [NUM_REGS-1:0]       busy_vec;
  logic [7:0]                outstanding;
  logic                      err_underflow;

  modport master (
    output src_valid, src_reg, iss_valid, iss_dst_valid, iss_dst_reg,
    output wb_valid, wb_reg, flush,
    input  iss_ready, busy_vec, outstanding, err_underflow
  );

  modport slave (
    input  src_valid, src_reg, iss_valid, iss_dst_valid, iss_dst_reg,
    input  wb_valid, wb_reg, flush,
    output iss_ready, busy_vec, outstanding, err_underflow
  );
endinterface
`default_nettype wire

// File: rtl/reg_scoreboard.sv
`default_nettype none
// ---------------------------------------------------------------------------
// reg_scoreboard : saturating per-register pending-writer scoreboard
// Rev 1.0
// ---------------------------------------------------------------------------
module reg_scoreboard #(
  parameter int NUM_REGS = 33,
  parameter int IDX_W    = 6,
  parameter int CNT_W    = 2,
  parameter int NUM_SRC  = 3,
  parameter int NUM_WB   = 2,
  parameter int BYPASS   = 1
) (
  input  wire logic          clk,
  input  wire logic          rst_n,
  reg_scoreboard_if.slave    sb
);
  localparam int DEC_W   = $clog2(NUM_WB + 1);
  localparam int CMP_W   = ((DEC_W > CNT_W) ? DEC_W : CNT_W) + 1;
  localparam int TOT_RAW = CNT_W + $clog2(NUM_REGS) + 1;
  localparam int TOT_W   = (TOT_RAW > 9) ? TOT_RAW : 9;
  localparam logic [CNT_W-1:0] C_CNT_MAX = '1;

  logic [CNT_W-1:0]    count_q [NUM_REGS];
  logic [CNT_W-1:0]    count_d [NUM_REGS];
  logic [7:0]          outstanding_q, outstanding_d;
  logic                err_q, err_d;

  logic [NUM_REGS-1:0] w_inc_req;
  logic [DEC_W-1:0]    w_dec [NUM_REGS];
  logic                w_src_conflict;
  logic                w_dst_block;
  logic                w_ready;
  logic                w_accept;
  logic                w_underflow;
  logic [TOT_W-1:0]    w_total;

  // Per-register decode of the presented destinations and the writeback ports.
  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) begin
      w_inc_req[r] = 1'b0;
      w_dec[r]     = '0;
      for (int j = 0; j < 2; j++) begin
        if (sb.iss_dst_valid[j] && (sb.iss_dst_reg[j*IDX_W +: IDX_W] == IDX_W'(r)))
          w_inc_req[r] = 1'b1;
      end
      for (int k = 0; k < NUM_WB; k++) begin
        if (sb.wb_valid[k] && (sb.wb_reg[k*IDX_W +: IDX_W] == IDX_W'(r)))
          w_dec[r] = w_dec[r] + DEC_W'(1);
      end
    end
  end

  // Bypass looks only at releases: the micro-op's own write lands after its read,
  // so it must not re-block its source (and this keeps ready free of a loop).
  always_comb begin
    w_src_conflict = 1'b0;
    w_dst_block    = 1'b0;
    for (int r = 0; r < NUM_REGS; r++) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (sb.src_valid[i] && (sb.src_reg[i*IDX_W +: IDX_W] == IDX_W'(r)) &&
            (count_q[r] != '0)) begin
          if (!((BYPASS != 0) && (CMP_W'(w_dec[r]) >= CMP_W'(count_q[r]))))
            w_src_conflict = 1'b1;
        end
      end
      if (w_inc_req[r] && (count_q[r] == C_CNT_MAX))
        w_dst_block = 1'b1;
    end
  end

  assign w_ready  = rst_n && !sb.flush && !w_src_conflict && !w_dst_block;
  assign w_accept = sb.iss_valid && w_ready;

  always_comb begin
    logic [CMP_W-1:0] sum;
    logic [CMP_W-1:0] dec;
    logic [CMP_W-1:0] net;
    w_underflow = 1'b0;
    for (int r = 0; r < NUM_REGS; r++) begin
      sum = CMP_W'(count_q[r]) + CMP_W'(w_accept && w_inc_req[r]);
      dec = CMP_W'(w_dec[r]);
      net = '0;
      if (sb.flush) begin
        count_d[r] = '0;
      end else if (dec > sum) begin
        count_d[r]  = '0;
        w_underflow = 1'b1;
      end else begin
        net        = sum - dec;
        count_d[r] = (net > CMP_W'(C_CNT_MAX)) ? C_CNT_MAX : net[CNT_W-1:0];
      end
    end
  end

  always_comb begin
    w_total = '0;
    for (int r = 0; r < NUM_REGS; r++)
      w_total = w_total + TOT_W'(count_d[r]);
    outstanding_d = (w_total > TOT_W'(255)) ? 8'hFF : w_total[7:0];
    err_d         = err_q | w_underflow;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NUM_REGS; r++)
        count_q[r] <= '0;
      outstanding_q <= '0;
      err_q         <= 1'b0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++)
        count_q[r] <= count_d[r];
      outstanding_q <= outstanding_d;
      err_q         <= err_d;
    end
  end

  generate
    for (genvar gr = 0; gr < NUM_REGS; gr++) begin : g_busy
      assign sb.busy_vec[gr] = |count_q[gr];
    end
  endgenerate

  assign sb.iss_ready     = w_ready;
  assign sb.outstanding   = outstanding_q;
  assign sb.err_underflow = err_q;
endmodule
`default_nettype wire

// File: tb/tb_reg_scoreboard.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_reg_scoreboard : directed self-checking bench for reg_scoreboard
// Rev 1.0
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_reg_scoreboard;
  localparam int NUM_REGS = 33;
  localparam int IDX_W    = 6;
  localparam int CNT_W    = 2;
  localparam int NUM_SRC  = 3;
  localparam int NUM_WB   = 2;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_errors = 0;

  reg_scoreboard_if #(
    .NUM_REGS(NUM_REGS), .IDX_W(IDX_W), .NUM_SRC(NUM_SRC), .NUM_WB(NUM_WB)
  ) sb_if ();

  reg_scoreboard #(
    .NUM_REGS(NUM_REGS), .IDX_W(IDX_W), .CNT_W(CNT_W),
    .NUM_SRC(NUM_SRC), .NUM_WB(NUM_WB), .BYPASS(1)
  ) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .sb    (sb_if)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    sb_if.src_valid     = '0;
    sb_if.src_reg       = '0;
    sb_if.iss_valid     = 1'b0;
    sb_if.iss_dst_valid = '0;
    sb_if.iss_dst_reg   = '0;
    sb_if.wb_valid      = '0;
    sb_if.wb_reg        = '0;
    sb_if.flush         = 1'b0;
  endtask

  task automatic drv_issue(input logic v0, input int d0, input logic v1, input int d1);
    sb_if.iss_valid     = 1'b1;
    sb_if.iss_dst_valid = {v1, v0};
    sb_if.iss_dst_reg   = {IDX_W'(d1), IDX_W'(d0)};
  endtask

  task automatic drv_src(input int i, input int r);
    sb_if.src_valid[i]               = 1'b1;
    sb_if.src_reg[i*IDX_W +: IDX_W]  = IDX_W'(r);
  endtask

  task automatic drv_wb(input int k, input int r);
    sb_if.wb_valid[k]              = 1'b1;
    sb_if.wb_reg[k*IDX_W +: IDX_W] = IDX_W'(r);
  endtask

  initial begin
    idle();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    sb_if.iss_valid = 1'b1;
    #2;
    check("rst_busy", 64'(sb_if.busy_vec), 64'h0);
    check("rst_outstanding", 64'(sb_if.outstanding), 64'h0);
    check("rst_err", 64'(sb_if.err_underflow), 64'h0);
    check("rst_ready", 64'(sb_if.iss_ready), 64'h0);
    step();
    step();
    rst_n = 1'b1;
    idle();

    // Single issue to reg 0, source hazard, bypassed release.
    drv_issue(1'b1, 0, 1'b0, 0);
    #1 check("iss0_ready", 64'(sb_if.iss_ready), 64'h1);
    step(); idle();
    check("iss0_busy", 64'(sb_if.busy_vec), 64'h1);
    check("iss0_outstanding", 64'(sb_if.outstanding), 64'h1);
    sb_if.iss_valid = 1'b1;
    drv_src(0, 0);
    #1 check("raw_blocked", 64'(sb_if.iss_ready), 64'h0);
    drv_wb(0, 0);
    #1 check("raw_bypass_ready", 64'(sb_if.iss_ready), 64'h1);
    step(); idle();
    check("wb0_busy", 64'(sb_if.busy_vec), 64'h0);
    check("wb0_outstanding", 64'(sb_if.outstanding), 64'h0);

    // WAW depth saturation on reg 5.
    for (int n = 1; n <= 3; n++) begin
      drv_issue(1'b1, 5, 1'b0, 0);
      #1 check("sat_ready", 64'(sb_if.iss_ready), 64'h1);
      step(); idle();
      check("sat_count", 64'(sb_if.outstanding), 64'(n));
    end
    drv_issue(1'b1, 5, 1'b0, 0);
    #1 check("sat_fourth_blocked", 64'(sb_if.iss_ready), 64'h0);
    step(); idle();
    check("sat_hold", 64'(sb_if.outstanding), 64'h3);
    drv_wb(1, 5);
    step(); idle();
    check("sat_after_wb", 64'(sb_if.outstanding), 64'h2);
    drv_issue(1'b1, 5, 1'b0, 0);
    #1 check("sat_reopen_ready", 64'(sb_if.iss_ready), 64'h1);
    step(); idle();
    check("sat_refill", 64'(sb_if.outstanding), 64'h3);
    drv_wb(0, 5); drv_wb(1, 5);
    step(); idle();
    drv_wb(0, 5);
    step(); idle();
    check("sat_drained", 64'(sb_if.busy_vec), 64'h0);

    // Simultaneous issue and release of reg 7.
    drv_issue(1'b1, 7, 1'b0, 0);
    step(); idle();
    drv_issue(1'b1, 7, 1'b0, 0);
    drv_wb(0, 7);
    step(); idle();
    check("same_outstanding", 64'(sb_if.outstanding), 64'h1);
    check("same_busy", 64'(sb_if.busy_vec), 64'h80);
    check("same_err", 64'(sb_if.err_underflow), 64'h0);
    drv_wb(0, 7);
    step(); idle();

    // Duplicate destinations and duplicate releases on reg 9.
    drv_issue(1'b1, 9, 1'b1, 9);
    step(); idle();
    check("dup_dst_count", 64'(sb_if.outstanding), 64'h1);
    drv_issue(1'b1, 9, 1'b0, 0);
    step(); idle();
    check("dup_dst_count2", 64'(sb_if.outstanding), 64'h2);
    drv_wb(0, 9); drv_wb(1, 9);
    step(); idle();
    check("dup_wb_count", 64'(sb_if.outstanding), 64'h0);
    check("dup_wb_err", 64'(sb_if.err_underflow), 64'h0);

    // Out-of-range indices: never conflict, never raise the error.
    sb_if.iss_valid = 1'b1;
    drv_src(2, 40);
    drv_wb(0, 40);
    #1 check("oor_src_ready", 64'(sb_if.iss_ready), 64'h1);
    step(); idle();
    check("oor_wb_err", 64'(sb_if.err_underflow), 64'h0);

    // Five registers busy, then flush.
    drv_issue(1'b1, 1, 1'b1, 2); step(); idle();
    drv_issue(1'b1, 3, 1'b1, 4); step(); idle();
    drv_issue(1'b1, 6, 1'b0, 0); step(); idle();
    check("pre_flush_busy", 64'(sb_if.busy_vec), 64'h5E);
    check("pre_flush_outstanding", 64'(sb_if.outstanding), 64'h5);
    sb_if.flush = 1'b1;
    drv_issue(1'b1, 8, 1'b0, 0);
    drv_wb(0, 1);
    #1 check("flush_ready", 64'(sb_if.iss_ready), 64'h0);
    step(); idle();
    check("flush_busy", 64'(sb_if.busy_vec), 64'h0);
    check("flush_outstanding", 64'(sb_if.outstanding), 64'h0);
    check("flush_err", 64'(sb_if.err_underflow), 64'h0);
    drv_wb(0, 3);
    step(); idle();
    check("uf_set", 64'(sb_if.err_underflow), 64'h1);
    step(); step();
    check("uf_sticky", 64'(sb_if.err_underflow), 64'h1);

    // Asynchronous reset while counts are nonzero.
    drv_issue(1'b1, 10, 1'b0, 0);
    step(); idle();
    check("pre_rst_busy", 64'(sb_if.busy_vec), 64'h400);
    rst_n = 1'b0;
    #1;
    check("async_busy", 64'(sb_if.busy_vec), 64'h0);
    check("async_outstanding", 64'(sb_if.outstanding), 64'h0);
    check("async_err", 64'(sb_if.err_underflow), 64'h0);
    check("async_ready", 64'(sb_if.iss_ready), 64'h0);
    step();
    check("rst_hold_ready", 64'(sb_if.iss_ready), 64'h0);
    rst_n = 1'b1;
    #1 check("post_rst_ready", 64'(sb_if.iss_ready), 64'h1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
`default_nettype wire
